// File: rtl/jt12_op_sched_if.sv
// Bus between the register interface/operator datapath and the slot sequencer.
// The sequencer takes the slave side: it receives the config writes and drives the strobes and selects.
interface jt12_op_sched_if;
  logic       clk_en;
  logic       cfg_we;
  logic [2:0] cfg_ch;
  logic [2:0] cfg_alg;
  logic [2:0] cfg_fb;
  logic [4:0] slot;
  logic [2:0] cur_ch;
  logic       s1_enters;
  logic       s3_enters;
  logic       s2_enters;
  logic       s4_enters;
  logic       zero;
  logic       xuse_prevprev1;
  logic       xuse_prev2;
  logic       xuse_internal;
  logic       yuse_prev1;
  logic       yuse_prev2;
  logic       yuse_internal;
  logic [2:0] fb_II;

  modport slave (
    input  clk_en, cfg_we, cfg_ch, cfg_alg, cfg_fb,
    output slot, cur_ch, s1_enters, s3_enters, s2_enters, s4_enters, zero,
           xuse_prevprev1, xuse_prev2, xuse_internal,
           yuse_prev1, yuse_prev2, yuse_internal, fb_II
  );

  modport master (
    output clk_en, cfg_we, cfg_ch, cfg_alg, cfg_fb,
    input  slot, cur_ch, s1_enters, s3_enters, s2_enters, s4_enters, zero,
           xuse_prevprev1, xuse_prev2, xuse_internal,
           yuse_prev1, yuse_prev2, yuse_internal, fb_II
  );
endinterface

// File: rtl/jt12_op_sched.sv
// FM operator slot sequencer: 24-slot cycle (6 channels x 4 operators), per-channel
// algorithm/feedback storage, operand-source selects and stage-II feedback level.
module jt12_op_sched #(
  parameter int NUM_CH = 6
) (
  input logic clk,
  input logic rst_n,
  jt12_op_sched_if.slave bus
);
  localparam int NUM_SLOTS = 4 * NUM_CH;

  logic [4:0] slot;
  logic [2:0] cur_ch;
  logic [2:0] alg_mem [NUM_CH];
  logic [2:0] fb_mem  [NUM_CH];
  logic [2:0] cur_alg;
  logic [2:0] cur_fb;
  logic [2:0] fb_II;
  logic [7:0] a_set;
  logic       s1, s3, s2, s4;
  logic       cfg_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (bus.clk_en) begin
      slot <= (slot == 5'(NUM_SLOTS - 1)) ? 5'd0 : slot + 5'd1;
    end
  end

  assign cur_ch = 3'(slot % 5'(NUM_CH));

  // Operators enter in the order S1, S3, S2, S4, one channel per slot within each group.
  assign s1 = (slot <  5'(NUM_CH));
  assign s3 = (slot >= 5'(NUM_CH))     && (slot < 5'(2 * NUM_CH));
  assign s2 = (slot >= 5'(2 * NUM_CH)) && (slot < 5'(3 * NUM_CH));
  assign s4 = (slot >= 5'(3 * NUM_CH));

  assign cfg_wr = bus.clk_en && bus.cfg_we && (bus.cfg_ch < 3'(NUM_CH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        alg_mem[i] <= '0;
        fb_mem[i]  <= '0;
      end
    end else if (cfg_wr) begin
      alg_mem[bus.cfg_ch] <= bus.cfg_alg;
      fb_mem[bus.cfg_ch]  <= bus.cfg_fb;
    end
  end

  assign cur_alg = alg_mem[cur_ch];
  assign cur_fb  = fb_mem[cur_ch];

  // Feedback follows the operator into stage II, one advance behind the read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_II <= '0;
    end else if (bus.clk_en) begin
      fb_II <= cur_fb;
    end
  end

  assign a_set = 8'd1 << cur_alg;

  always_comb begin
    bus.slot           = slot;
    bus.cur_ch         = cur_ch;
    bus.s1_enters      = s1;
    bus.s3_enters      = s3;
    bus.s2_enters      = s2;
    bus.s4_enters      = s4;
    bus.zero           = (slot == 5'd0);
    bus.xuse_prevprev1 = s1 | (s3 & a_set[5]);
    bus.xuse_prev2     = (s3 & (a_set[0] | a_set[1] | a_set[2])) | (s4 & a_set[3]);
    bus.xuse_internal  = s4 & a_set[2];
    bus.yuse_prev1     = s1 | (s3 & a_set[1])
                       | (s2 & (a_set[0] | a_set[3] | a_set[4] | a_set[5] | a_set[6]))
                       | (s4 & (a_set[2] | a_set[5]));
    bus.yuse_prev2     = 1'b0;
    bus.yuse_internal  = s4 & (a_set[0] | a_set[1] | a_set[3] | a_set[4]);
    bus.fb_II          = fb_II;
  end
endmodule

// File: tb/tb_jt12_op_sched.sv
// Randomized and directed checks of the slot sequencer against a slot/table reference model.
module tb_jt12_op_sched;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  jt12_op_sched_if bus ();

  jt12_op_sched #(.NUM_CH(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  int         m_slot;
  logic [2:0] m_alg [6];
  logic [2:0] m_fb  [6];
  logic [2:0] m_fbii;

  // Per-stage (S1,S3,S2,S4) masks of algorithms that enable each select.
  localparam logic [7:0] XPP1_M [4] = '{8'hFF, 8'h20, 8'h00, 8'h00};
  localparam logic [7:0] XP2_M  [4] = '{8'h00, 8'h07, 8'h00, 8'h08};
  localparam logic [7:0] XINT_M [4] = '{8'h00, 8'h00, 8'h00, 8'h04};
  localparam logic [7:0] YP1_M  [4] = '{8'hFF, 8'h02, 8'h79, 8'h24};
  localparam logic [7:0] YINT_M [4] = '{8'h00, 8'h00, 8'h00, 8'h1B};

  task automatic model_reset();
    m_slot = 0;
    m_fbii = '0;
    for (int i = 0; i < 6; i++) begin
      m_alg[i] = '0;
      m_fb[i]  = '0;
    end
  endtask

  // Layout: slot[21:17] cur_ch[16:14] {s1,s3,s2,s4}[13:10] zero[9] selects[8:3] fb_II[2:0]
  function automatic logic [21:0] exp_vec();
    int         st  = m_slot / 6;
    int         ch  = m_slot % 6;
    logic [2:0] a   = m_alg[ch];
    logic [3:0] stb = 4'b1000 >> st;
    logic [5:0] sel = {XPP1_M[st][a], XP2_M[st][a], XINT_M[st][a], YP1_M[st][a], 1'b0, YINT_M[st][a]};
    return {5'(m_slot), 3'(ch), stb, (m_slot == 0), sel, m_fbii};
  endfunction

  function automatic logic [21:0] obs_vec();
    return {bus.slot, bus.cur_ch, bus.s1_enters, bus.s3_enters, bus.s2_enters, bus.s4_enters,
            bus.zero, bus.xuse_prevprev1, bus.xuse_prev2, bus.xuse_internal,
            bus.yuse_prev1, bus.yuse_prev2, bus.yuse_internal, bus.fb_II};
  endfunction

  // One clock edge; the model advances only when enabled, reading fb before any write lands.
  task automatic step(input logic en, input logic we, input logic [2:0] ch,
                      input logic [2:0] alg, input logic [2:0] fb);
    bus.clk_en  = en;
    bus.cfg_we  = we;
    bus.cfg_ch  = ch;
    bus.cfg_alg = alg;
    bus.cfg_fb  = fb;
    @(posedge clk);
    if (en) begin
      m_fbii = m_fb[m_slot % 6];
      if (we && ch < 3'd6) begin
        m_alg[ch] = alg;
        m_fb[ch]  = fb;
      end
      m_slot = (m_slot + 1) % 24;
    end
    #1;
  endtask

  task automatic goto_slot(input int n);
    for (int k = 0; k < 24 && m_slot != n; k++) step(1'b1, 1'b0, 3'd0, 3'd0, 3'd0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.clk_en = 1'b1; bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_alg = '0; bus.cfg_fb = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (obs_vec() !== 22'b00000_000_1000_1_100100_000) begin
      n_err++;
      $display("FAIL reset_state: got %b want %b", obs_vec(), 22'b00000_000_1000_1_100100_000);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_slot_cycle();
    for (int i = 0; i < 25; i++) begin
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL slot_cycle[%0d]: got %b want %b", i, obs_vec(), exp_vec());
      end
      step(1'b1, 1'b0, 3'd0, 3'd0, 3'd0);
    end
  endtask

  task automatic test_clk_en();
    for (int i = 0; i < 30; i++) begin
      logic en = (i % 3 == 0);
      step(en, ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 5)),
           3'($urandom), 3'($urandom));
      n_cmp++;
      if (bus.slot !== 5'(m_slot)) begin
        n_err++;
        $display("FAIL clk_en_slot[%0d]: got %0d want %0d", i, bus.slot, m_slot);
      end
    end
    for (int i = 0; i < 24; i++) begin
      step(1'b1, 1'b0, 3'd0, 3'd0, 3'd0);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL clk_en_cfg_held[%0d]: got %b want %b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_alg_directed();
    step(1'b1, 1'b1, 3'd2, 3'd0, 3'd0);
    step(1'b1, 1'b1, 3'd4, 3'd7, 3'd0);
    goto_slot(8);
    n_cmp++;
    if (obs_vec() [8:3] !== 6'b010000) begin
      n_err++; $display("FAIL ch2_slot8: got %b want %b", obs_vec() [8:3], 6'b010000);
    end
    goto_slot(10);
    n_cmp++;
    if (obs_vec() [8:3] !== 6'b000000) begin
      n_err++; $display("FAIL ch4_slot10: got %b want %b", obs_vec() [8:3], 6'b000000);
    end
    goto_slot(14);
    n_cmp++;
    if (obs_vec() [8:3] !== 6'b000100) begin
      n_err++; $display("FAIL ch2_slot14: got %b want %b", obs_vec() [8:3], 6'b000100);
    end
    goto_slot(16);
    n_cmp++;
    if (obs_vec() [8:3] !== 6'b000000) begin
      n_err++; $display("FAIL ch4_slot16: got %b want %b", obs_vec() [8:3], 6'b000000);
    end
    goto_slot(20);
    n_cmp++;
    if (obs_vec() [8:3] !== 6'b000001) begin
      n_err++; $display("FAIL ch2_slot20: got %b want %b", obs_vec() [8:3], 6'b000001);
    end
    goto_slot(22);
    n_cmp++;
    if (obs_vec() [8:3] !== 6'b000000) begin
      n_err++; $display("FAIL ch4_slot22: got %b want %b", obs_vec() [8:3], 6'b000000);
    end
    goto_slot(4);
    n_cmp++;
    if (obs_vec() [8:3] !== 6'b100100) begin
      n_err++; $display("FAIL ch4_slot4: got %b want %b", obs_vec() [8:3], 6'b100100);
    end
  endtask

  task automatic test_fb();
    for (int c = 0; c < 6; c++)
      step(1'b1, 1'b1, 3'(c), m_alg[c], (c == 3) ? 3'd5 : 3'd0);
    goto_slot(0);
    for (int i = 0; i < 24; i++) begin
      step(1'b1, 1'b0, 3'd0, 3'd0, 3'd0);
      n_cmp++;
      if (bus.fb_II !== m_fbii) begin
        n_err++;
        $display("FAIL fb_II[slot %0d]: got %0d want %0d", m_slot, bus.fb_II, m_fbii);
      end
      if (m_slot == 4) begin
        n_cmp++;
        if (bus.fb_II !== 3'd5) begin
          n_err++; $display("FAIL fb_II_slot4: got %0d want 5", bus.fb_II);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), 3'($urandom),
           3'($urandom), 3'($urandom));
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL random[%0d]: got %b want %b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_write_and_reset();
    step(1'b1, 1'b1, 3'd1, 3'd0, 3'd0);
    goto_slot(7);
    bus.clk_en = 1'b1; bus.cfg_we = 1'b1; bus.cfg_ch = 3'd1; bus.cfg_alg = 3'd4; bus.cfg_fb = 3'd0;
    #1;
    n_cmp++;
    if (obs_vec() [8:3] !== 6'b010000) begin
      n_err++; $display("FAIL same_cycle_old: got %b want %b", obs_vec() [8:3], 6'b010000);
    end
    step(1'b1, 1'b1, 3'd1, 3'd4, 3'd0);
    goto_slot(7);
    n_cmp++;
    if (obs_vec() [8:3] !== 6'b000000) begin
      n_err++; $display("FAIL same_cycle_new: got %b want %b", obs_vec() [8:3], 6'b000000);
    end
    step(1'b1, 1'b1, 3'd3, 3'd6, 3'd7);
    goto_slot(13);
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (obs_vec() !== exp_vec()) begin
      n_err++; $display("FAIL mid_reset: got %b want %b", obs_vec(), exp_vec());
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 24; i++) begin
      step(1'b1, 1'b0, 3'd0, 3'd0, 3'd0);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL post_reset_cfg[%0d]: got %b want %b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    test_reset();
    test_slot_cycle();
    test_clk_en();
    test_alg_directed();
    test_fb();
    test_random();
    test_write_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
